ddr3_read_unpack: RTL

- Read-return stage directly downstream of the DDR3 command scheduler's read path.
- Captures 128-bit read beats from the DDR3 controller's read-data port, which has no backpressure, into a small credit-managed FIFO.
- Serialises each beat MSB-first into an 8-bit AXI4-Stream towards the USB transmit FIFO, with tlast on the final byte of a burst.
- The scheduler issues a read only when this block reports a free credit, so no read data is ever dropped in normal operation.

---
 rtl/ddr3_read_unpack_pkg.sv | 24 ++
 rtl/ddr3_read_unpack_fifo.sv | 59 +++++
 rtl/ddr3_read_unpack.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ddr3_read_unpack_pkg.sv
// Shared DDR3 read/write data-path constants and serialiser types.
// The beat geometry is also used by the write-data packer, so keep it here.
package ddr3_read_unpack_pkg;

    localparam int DDR3_BEAT_BITS = 128;
    localparam int BYTES_PER_BEAT = 16;
    localparam int AXIS_BYTE_BITS = 8;
    localparam int BYTE_CNT_BITS  = $clog2(BYTES_PER_BEAT);
    localparam int RD_ENTRY_BITS  = DDR3_BEAT_BITS + 1;

    localparam logic [BYTE_CNT_BITS-1:0] LAST_BYTE_IDX = BYTE_CNT_BITS'(BYTES_PER_BEAT - 1);

    // One buffered read beat; 'last' marks the final beat of a frame.
    typedef struct packed {
        logic                      last;
        logic [DDR3_BEAT_BITS-1:0] data;
    } rd_entry_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ser_state_t;

endpackage

// File: rtl/ddr3_read_unpack_fifo.sv
// Small synchronous FIFO with flop-array storage and full/empty flags.
// The head word is always presented on o_rd_data (no fall-through from the
// write port), so data written on one edge is poppable on the next edge.
// A write while full succeeds when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH      = 129,
    parameter int DEPTH_BITS = 2
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int DEPTH = 1 << DEPTH_BITS;

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [DEPTH_BITS:0] r_wr_ptr;
    logic [DEPTH_BITS:0] r_rd_ptr;
    logic                w_do_rd;
    logic                w_do_wr;

    // Extra pointer MSB separates the full case from the empty case.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[DEPTH_BITS] != r_rd_ptr[DEPTH_BITS]) &&
                     (r_wr_ptr[DEPTH_BITS-1:0] == r_rd_ptr[DEPTH_BITS-1:0]);

    assign w_do_rd = i_rd_en & ~o_empty;
    assign w_do_wr = i_wr_en & (~o_full | w_do_rd);

    assign o_rd_data = r_mem[r_rd_ptr[DEPTH_BITS-1:0]];

    // Storage array; contents need no reset since the pointers gate visibility.
    always_ff @(posedge i_clock) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr[DEPTH_BITS-1:0]] <= i_wr_data;
        end
    end

    // Read/write pointers.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr3_read_unpack.sv
// DDR3 read-return stage: buffers 128-bit read beats and serialises them
// MSB-first onto an 8-bit AXI4-Stream, issuing read credits to the scheduler.
//
// Serialiser states:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | shifter empty, m_tvalid low, waiting for a buffered beat
//   ST_SEND | shifter holds a beat, presenting byte r_cnt on the stream
module ddr3_read_unpack
    import ddr3_read_unpack_pkg::*;
#(
    parameter int DEPTH_BITS = 2,
    parameter int DATA_WIDTH = 128,
    parameter int AXIS_WIDTH = 8
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_rq_issue,
    output logic [DEPTH_BITS:0]   o_rd_space,
    input  logic                  i_dr_valid,
    input  logic                  i_dr_last,
    input  logic [DATA_WIDTH-1:0] i_dr_data,
    output logic                  o_m_tvalid,
    input  logic                  i_m_tready,
    output logic                  o_m_tlast,
    output logic [AXIS_WIDTH-1:0] o_m_tdata,
    output logic                  o_err_ovf,
    output logic                  o_err_cred
);

    localparam logic [DEPTH_BITS:0] SPACE_MAX = {1'b1, {DEPTH_BITS{1'b0}}};

    // Credit state.
    logic [DEPTH_BITS:0]        r_rd_space;
    logic [DEPTH_BITS:0]        w_space_next;
    logic                       w_issue_ok;

    // FIFO interface.
    rd_entry_t                  w_wr_entry;
    rd_entry_t                  w_head;
    logic                       w_fifo_full;
    logic                       w_fifo_empty;

    // Serialiser state.
    ser_state_t                 r_state;
    ser_state_t                 w_state_next;
    logic [DDR3_BEAT_BITS-1:0]  r_shift;
    logic                       r_last;
    logic [BYTE_CNT_BITS-1:0]   r_cnt;
    logic                       w_accept;
    logic                       w_final;
    logic                       w_load;

    // Sticky error flags.
    logic                       r_err_ovf;
    logic                       r_err_cred;

    assign w_wr_entry.last = i_dr_last;
    assign w_wr_entry.data = i_dr_data;

    sync_fifo #(
        .WIDTH      (RD_ENTRY_BITS),
        .DEPTH_BITS (DEPTH_BITS)
    ) u_fifo (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_wr_en   (i_dr_valid),
        .i_wr_data (w_wr_entry),
        .i_rd_en   (w_load),
        .o_rd_data (w_head),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    // A load either fills an idle shifter or chains onto the final byte
    // handshake, which is what keeps back-to-back beats bubble-free.
    assign w_accept = (r_state == ST_SEND) & i_m_tready;
    assign w_final  = w_accept & (r_cnt == LAST_BYTE_IDX);
    assign w_load   = ~w_fifo_empty & ((r_state == ST_IDLE) | w_final);

    // Serialiser next-state.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_load) begin
                    w_state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_final && !w_load) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Serialiser state register.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Shifter and byte counter; the outgoing byte is always the top byte.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_shift <= '0;
            r_last  <= 1'b0;
            r_cnt   <= '0;
        end else if (w_load) begin
            r_shift <= w_head.data;
            r_last  <= w_head.last;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_shift <= r_shift << AXIS_BYTE_BITS;
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign o_m_tvalid = (r_state == ST_SEND);
    assign o_m_tdata  = r_shift[DDR3_BEAT_BITS-1 -: AXIS_BYTE_BITS];
    assign o_m_tlast  = o_m_tvalid & r_last & (r_cnt == LAST_BYTE_IDX);

    // Credits: an issue with no credit left is refused; a pop returns one
    // credit but never beyond the FIFO depth, since beats can also arrive
    // without a prior reservation.
    assign w_issue_ok = i_rq_issue & (r_rd_space != '0);

    // Credit next-value.
    always_comb begin
        w_space_next = r_rd_space;
        case ({w_load, w_issue_ok})
            2'b10: begin
                if (r_rd_space != SPACE_MAX) begin
                    w_space_next = r_rd_space + 1'b1;
                end
            end
            2'b01:   w_space_next = r_rd_space - 1'b1;
            default: w_space_next = r_rd_space;
        endcase
    end

    // Credit register.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_rd_space <= SPACE_MAX;
        end else begin
            r_rd_space <= w_space_next;
        end
    end

    assign o_rd_space = r_rd_space;

    // Sticky errors; an overflow only counts when no pop frees a slot this edge.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_err_ovf  <= 1'b0;
            r_err_cred <= 1'b0;
        end else begin
            if (i_dr_valid && w_fifo_full && !w_load) begin
                r_err_ovf <= 1'b1;
            end
            if (i_rq_issue && (r_rd_space == '0)) begin
                r_err_cred <= 1'b1;
            end
        end
    end

    assign o_err_ovf  = r_err_ovf;
    assign o_err_cred = r_err_cred;

endmodule
